// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : press_classifier
// Description : Classifies presses of a debounced, already-synchronous button
//               level into one-cycle short / long / double pulses.
//               Optional feature macro: PRESS_CLASSIFIER_DOUBLE_EN (enables
//               double-press detection via the WAIT_GAP / SECOND_PRESS states).
// Revision    : 1.0 - initial release
// ============================================================================
module press_classifier #(
    parameter int LongCycles = 1000,
    parameter int GapCycles  = 300
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic short_o,
    output logic long_o,
    output logic double_o,
    output logic busy_o
);

    // One counter serves both the press-length and the release-gap timing.
    localparam int C_CNT_MAX = (LongCycles > GapCycles) ? LongCycles : GapCycles;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX);

    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_LONG_LAST = C_CNT_W'(LongCycles - 1);
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GapCycles - 1);
`endif

`ifdef PRESS_CLASSIFIER_DOUBLE_EN
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRESSED      = 3'd1,
        S_LONG_HELD    = 3'd2,
        S_WAIT_GAP     = 3'd3,
        S_SECOND_PRESS = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRESSED      = 3'd1,
        S_LONG_HELD    = 3'd2
    } state_t;
`endif

    state_t               state_q;
    logic [C_CNT_W-1:0]   cnt_q;
    logic                 level_q;
    logic                 armed_q;
    logic                 short_q;
    logic                 long_q;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
    logic                 double_q;
`endif

    logic w_rise;
    logic w_fall;

    assign w_rise = level_i & ~level_q;
    assign w_fall = ~level_i & level_q;

    // Edge tracking, arming, classification FSM and registered pulse outputs.
    // Arming requires one low sample after reset, so a button held through
    // reset release is never taken as a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            armed_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
            double_q <= 1'b0;
`endif
        end else begin
            level_q <= level_i;
            if (!level_i) begin
                armed_q <= 1'b1;
            end
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
            double_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_rise && armed_q) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                    end
                end
                S_PRESSED: begin
                    if (w_fall) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
                        state_q <= S_WAIT_GAP;
`else
                        state_q <= S_IDLE;
                        short_q <= 1'b1;
`endif
                        cnt_q   <= '0;
                    end else if (level_i) begin
                        if (cnt_q == C_LONG_LAST) begin
                            state_q <= S_LONG_HELD;
                            long_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + C_CNT_ONE;
                        end
                    end
                end
                S_LONG_HELD: begin
                    // Already reported; just wait for release.
                    if (w_fall) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
                S_WAIT_GAP: begin
                    // A re-press wins over the terminal count in the same cycle.
                    if (w_rise) begin
                        state_q <= S_SECOND_PRESS;
                        cnt_q   <= '0;
                    end else if (cnt_q == C_GAP_LAST) begin
                        state_q <= S_IDLE;
                        short_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + C_CNT_ONE;
                    end
                end
                S_SECOND_PRESS: begin
                    // No long detection here: any release completes a double.
                    if (w_fall) begin
                        state_q  <= S_IDLE;
                        double_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign short_o = short_q;
    assign long_o  = long_q;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
    assign double_o = double_q;
`else
    assign double_o = 1'b0;
`endif
    assign busy_o  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_classifier
// Description : Self-checking bench for press_classifier (LongCycles=8,
//               GapCycles=4). Expected pulses come from a run-length model of
//               the sampled button level. Follows PRESS_CLASSIFIER_DOUBLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_classifier;

    localparam int L    = 8;
    localparam int GAP  = 4;
    localparam int MAXN = 2048;

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b1;
    logic level_i = 1'b0;
    logic short_o, long_o, double_o, busy_o;

    int checks   = 0;
    int failures = 0;

    bit   seq[$];
    logic rec_s[MAXN], rec_l[MAXN], rec_d[MAXN], rec_b[MAXN];
    bit   exp_s[MAXN], exp_l[MAXN], exp_d[MAXN], exp_b[MAXN];
    int   seq_n;

    press_classifier #(.LongCycles(L), .GapCycles(GAP)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (level_i),
        .short_o (short_o),
        .long_o  (long_o),
        .double_o(double_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_bit(input string tag, input int idx, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, idx, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic add_seg(input bit v, input int len);
        for (int i = 0; i < len; i++) seq.push_back(v);
    endtask

    task automatic drive(input bit v);
        @(negedge clk_i);
        level_i = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic record(input int e);
        rec_s[e] = short_o;
        rec_l[e] = long_o;
        rec_d[e] = double_o;
        rec_b[e] = busy_o;
    endtask

    function automatic int run_len(input int from, input bit v, input int n);
        int c = 0;
        while (from + c < n && seq[from + c] == v) c++;
        return c;
    endfunction

    task automatic mark_busy(input int a, input int b, input int n);
        for (int i = a; i < b && i < n; i++) exp_b[i] = 1'b1;
    endtask

    // Expected outputs after each edge, derived from run lengths of the
    // sampled level: a press starts on a low->high sample pair (never on the
    // first sample after reset), is long if high for more than L samples,
    // otherwise it is followed by a gap that either ends in a re-press within
    // GAP samples (double, reported at its release) or times out (short).
    task automatic build_model(input int n);
        int k, s, h, f;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        int g, r, h2, e;
`endif
        for (int i = 0; i < n; i++) begin
            exp_s[i] = 1'b0; exp_l[i] = 1'b0; exp_d[i] = 1'b0; exp_b[i] = 1'b0;
        end
        k = 1;
        while (k < n) begin
            if (!(seq[k] && !seq[k-1])) begin
                k++;
            end else begin
                s = k;
                h = run_len(s, 1'b1, n);
                if (h > L) begin
                    exp_l[s + L] = 1'b1;
                    mark_busy(s, s + h, n);
                    k = s + h;
                end else begin
                    f = s + h;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
                    g = run_len(f, 1'b0, n);
                    if (g <= GAP && f + g < n) begin
                        r  = f + g;
                        h2 = run_len(r, 1'b1, n);
                        e  = r + h2;
                        if (e < n) exp_d[e] = 1'b1;
                        mark_busy(s, e, n);
                        k = e;
                    end else begin
                        if (f + GAP < n) exp_s[f + GAP] = 1'b1;
                        mark_busy(s, f + GAP, n);
                        k = f + GAP + 1;
                    end
`else
                    if (f < n) exp_s[f] = 1'b1;
                    mark_busy(s, f, n);
                    k = f;
`endif
                end
            end
        end
    endtask

    // Reset (level held at the first sample), play seq edge by edge, compare.
    task automatic run_seq(input string tag);
        int n;
        n = seq.size();
        if (n > MAXN) n = MAXN;
        seq_n = n;
        @(negedge clk_i);
        rst_i   = 1'b1;
        level_i = seq[0];
        repeat (2) @(posedge clk_i);
        #1;
        check_bit({tag, "/rst_short"},  -1, short_o,  1'b0);
        check_bit({tag, "/rst_long"},   -1, long_o,   1'b0);
        check_bit({tag, "/rst_double"}, -1, double_o, 1'b0);
        check_bit({tag, "/rst_busy"},   -1, busy_o,   1'b0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        level_i = seq[0];
        @(posedge clk_i);
        #1;
        record(0);
        for (int e = 1; e < n; e++) begin
            drive(seq[e]);
            record(e);
        end
        build_model(n);
        for (int e = 0; e < n; e++) begin
            check_bit({tag, "/short"},  e, rec_s[e], exp_s[e]);
            check_bit({tag, "/long"},   e, rec_l[e], exp_l[e]);
            check_bit({tag, "/double"}, e, rec_d[e], exp_d[e]);
            check_bit({tag, "/busy"},   e, rec_b[e], exp_b[e]);
        end
    endtask

    function automatic int count_ones(input int which);
        int c = 0;
        for (int i = 0; i < seq_n; i++) begin
            if (which == 0 && rec_s[i] === 1'b1) c++;
            if (which == 1 && rec_l[i] === 1'b1) c++;
            if (which == 2 && rec_d[i] === 1'b1) c++;
        end
        return c;
    endfunction

    initial begin
        // Scenario 1: 3-sample press, no re-press
        seq.delete(); add_seg(0, 2); add_seg(1, 3); add_seg(0, 12);
        run_seq("s1");
        check_int("s1/short_count", count_ones(0), 1);
        check_int("s1/long_count", count_ones(1), 0);
        check_int("s1/double_count", count_ones(2), 0);
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        check_bit("s1/short_at_fall_plus4", 9, rec_s[9], 1'b1);
`else
        check_bit("s1/short_at_fall", 5, rec_s[5], 1'b1);
`endif

        // Scenario 2: 20-sample hold
        seq.delete(); add_seg(0, 2); add_seg(1, 20); add_seg(0, 6);
        run_seq("s2");
        check_bit("s2/long_edge", 10, rec_l[10], 1'b1);
        check_int("s2/long_count", count_ones(1), 1);
        check_int("s2/short_count", count_ones(0), 0);
        check_bit("s2/busy_held", 21, rec_b[21], 1'b1);
        check_bit("s2/busy_after_fall", 22, rec_b[22], 1'b0);

        // Scenario 3: quick double press
        seq.delete(); add_seg(0, 2); add_seg(1, 2); add_seg(0, 2); add_seg(1, 2); add_seg(0, 8);
        run_seq("s3");
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        check_bit("s3/double_edge", 8, rec_d[8], 1'b1);
        check_int("s3/double_count", count_ones(2), 1);
        check_int("s3/short_count", count_ones(0), 0);
`else
        check_int("s3/short_count", count_ones(0), 2);
`endif

        // Scenario 4: re-press exactly at the gap terminal count
        seq.delete(); add_seg(0, 2); add_seg(1, 2); add_seg(0, 4); add_seg(1, 2); add_seg(0, 8);
        run_seq("s4");
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        check_bit("s4/double_edge", 10, rec_d[10], 1'b1);
        check_int("s4/short_count", count_ones(0), 0);
`else
        check_int("s4/short_count", count_ones(0), 2);
`endif

        // Scenario 5: button held through reset release, then a real press
        seq.delete(); add_seg(1, 20); add_seg(0, 3); add_seg(1, 3); add_seg(0, 12);
        run_seq("s5");
        check_int("s5/long_count", count_ones(1), 0);
        check_int("s5/short_count", count_ones(0), 1);
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        check_bit("s5/short_edge", 30, rec_s[30], 1'b1);
`else
        check_bit("s5/short_edge", 26, rec_s[26], 1'b1);
`endif

        // Scenario 6: asynchronous reset mid-press (count reached 5)
        drive(1'b0); drive(1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1);
        check_bit("s6/busy_before_rst", 0, busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check_bit("s6/async_busy",   0, busy_o,   1'b0);
        check_bit("s6/async_short",  0, short_o,  1'b0);
        check_bit("s6/async_long",   0, long_o,   1'b0);
        check_bit("s6/async_double", 0, double_o, 1'b0);
        seq.delete(); add_seg(1, 12); add_seg(0, 8);
        run_seq("s6");
        check_int("s6/long_count", count_ones(1), 0);

        // Randomized press/release patterns around the thresholds
        seq.delete(); add_seg(0, 2);
        for (int i = 0; i < 90; i++) begin
            add_seg(1, $urandom_range(1, 12));
            add_seg(0, $urandom_range(1, 7));
        end
        add_seg(0, 10);
        run_seq("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
